// File: rtl/piradip_bit_sync_detect.sv
// Serial-bit frame synchronizer.
// Hunts for a fixed sync word in a one-bit-per-beat stream, then forwards only
// the payload bits of each frame, flagging the first one with out_align so the
// downstream packer can realign. The sync word is re-checked between frames
// and lock is released after MISS_LIMIT consecutive failed checks.
module piradip_bit_sync_detect #(
    parameter int                    SYNC_WIDTH = 32,
    parameter logic [SYNC_WIDTH-1:0] SYNC_WORD  = 32'h1ACFFC1D,
    parameter int                    FRAME_BITS = 1024,
    parameter int                    MAX_ERRORS = 0,
    parameter int                    MISS_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_data,
    output logic        out_align,
    output logic        locked,
    output logic        sync_lost,
    output logic [15:0] frame_count
);

    // One counter serves both the payload phase and the sync re-check phase,
    // so it has to hold the larger of the two lengths.
    localparam int CNT_MAX = (FRAME_BITS > SYNC_WIDTH) ? FRAME_BITS : SYNC_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int FILL_W  = $clog2(SYNC_WIDTH + 1);
    localparam int MISS_W  = (MISS_LIMIT > 1) ? $clog2(MISS_LIMIT) : 1;

    localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0]  SYNC_LAST  = CNT_W'(SYNC_WIDTH - 1);
    localparam logic [FILL_W-1:0] FILL_LAST  = FILL_W'(SYNC_WIDTH - 1);
    localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(SYNC_WIDTH);
    localparam logic [MISS_W-1:0] MISS_LAST  = MISS_W'(MISS_LIMIT - 1);

    typedef enum logic [1:0] {
        SEARCH,
        PAYLOAD,
        CHECK
    } state_t;

    state_t              state, state_n;
    logic [SYNC_WIDTH-1:0] sr, sr_n, sr_shift;
    logic [FILL_W-1:0]   fill_cnt, fill_n;
    logic [CNT_W-1:0]    bit_cnt, bit_n;
    logic [MISS_W-1:0]   miss_cnt, miss_n;
    logic [15:0]         fc_n;
    logic                locked_n;
    logic                lost_n;
    logic                armed, armed_n;
    logic                ov_n, od_n, oa_n;
    logic                accept;
    logic                match;

    // Number of positions where the window differs from the sync word.
    function automatic int hamming(input logic [SYNC_WIDTH-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < SYNC_WIDTH; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

    assign sr_shift = {sr[SYNC_WIDTH-2:0], in_data};
    assign match    = (hamming(sr_shift ^ SYNC_WORD) <= MAX_ERRORS);
    assign accept   = in_valid & in_ready;

    // Upstream is stalled only by a full output register during payload,
    // and held off entirely while reset is asserted.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            if (state == PAYLOAD) begin
                in_ready = ~out_valid | out_ready;
            end else begin
                in_ready = 1'b1;
            end
        end
    end

    // Next-state and next-value logic for the framing FSM and its datapath.
    always_comb begin
        state_n  = state;
        sr_n     = sr;
        fill_n   = fill_cnt;
        bit_n    = bit_cnt;
        miss_n   = miss_cnt;
        fc_n     = frame_count;
        locked_n = locked;
        lost_n   = 1'b0;
        armed_n  = armed;
        ov_n     = out_valid;
        od_n     = out_data;
        oa_n     = out_align;

        if (out_valid && out_ready) begin
            ov_n = 1'b0;
        end

        if (accept) begin
            sr_n = sr_shift;
            unique case (state)
                SEARCH: begin
                    if (fill_cnt != FILL_FULL) begin
                        fill_n = fill_cnt + 1'b1;
                    end
                    if ((fill_cnt >= FILL_LAST) && match) begin
                        state_n  = PAYLOAD;
                        locked_n = 1'b1;
                        fc_n     = frame_count + 16'd1;
                        armed_n  = 1'b1;
                        bit_n    = '0;
                    end
                end
                PAYLOAD: begin
                    ov_n    = 1'b1;
                    od_n    = in_data;
                    oa_n    = armed;
                    armed_n = 1'b0;
                    if (bit_cnt == FRAME_LAST) begin
                        bit_n   = '0;
                        state_n = CHECK;
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (bit_cnt == SYNC_LAST) begin
                        bit_n = '0;
                        if (match) begin
                            miss_n  = '0;
                            fc_n    = frame_count + 16'd1;
                            state_n = PAYLOAD;
                            armed_n = 1'b1;
                        end else if (miss_cnt == MISS_LAST) begin
                            miss_n   = '0;
                            fill_n   = '0;
                            state_n  = SEARCH;
                            locked_n = 1'b0;
                            lost_n   = 1'b1;
                        end else begin
                            miss_n  = miss_cnt + 1'b1;
                            state_n = PAYLOAD;
                            armed_n = 1'b1;
                        end
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = SEARCH;
                end
            endcase
        end
    end

    // State and datapath registers; reset discards any buffered output bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SEARCH;
            sr          <= '0;
            fill_cnt    <= '0;
            bit_cnt     <= '0;
            miss_cnt    <= '0;
            frame_count <= '0;
            locked      <= 1'b0;
            sync_lost   <= 1'b0;
            armed       <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= 1'b0;
            out_align   <= 1'b0;
        end else begin
            state       <= state_n;
            sr          <= sr_n;
            fill_cnt    <= fill_n;
            bit_cnt     <= bit_n;
            miss_cnt    <= miss_n;
            frame_count <= fc_n;
            locked      <= locked_n;
            sync_lost   <= lost_n;
            armed       <= armed_n;
            out_valid   <= ov_n;
            out_data    <= od_n;
            out_align   <= oa_n;
        end
    end

endmodule

// File: tb/tb_piradip_bit_sync_detect.sv
// Bench for piradip_bit_sync_detect: random bit stream with framed sync words,
// a position-based behavioural model, and a per-cycle compare process.
module tb_piradip_bit_sync_detect;

    localparam int          SW   = 32;
    localparam logic [31:0] SYNC = 32'h1ACFFC1D;
    localparam int          FB   = 64;
    localparam int          ML   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_data = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready, out_valid, out_data, out_align, locked, sync_lost;
    logic [15:0] frame_count;
    logic        t_in_ready, t_out_valid, t_out_data, t_out_align, t_locked, t_sync_lost;
    logic [15:0] t_frame_count;

    piradip_bit_sync_detect #(
        .SYNC_WIDTH(SW), .SYNC_WORD(SYNC), .FRAME_BITS(FB), .MAX_ERRORS(0), .MISS_LIMIT(ML)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_align(out_align), .locked(locked), .sync_lost(sync_lost),
        .frame_count(frame_count)
    );

    piradip_bit_sync_detect #(
        .SYNC_WIDTH(SW), .SYNC_WORD(SYNC), .FRAME_BITS(FB), .MAX_ERRORS(1), .MISS_LIMIT(ML)
    ) dut_tol (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t_in_ready), .in_data(in_data),
        .out_valid(t_out_valid), .out_ready(out_ready), .out_data(t_out_data),
        .out_align(t_out_align), .locked(t_locked), .sync_lost(t_sync_lost),
        .frame_count(t_frame_count)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    bit         chk_en = 1'b0;
    bit         bp_mode = 1'b0;
    int         bp_cnt = 0;
    int         lost_pulses = 0;
    logic [1:0] got_q[$];

    // Model state: lock flag, position within frame+sync period, fill/miss counts.
    bit          m_locked, m_occ, m_od, m_oa, m_lost;
    bit          m_rdy, m_hit;
    int          m_fill, m_pos, m_miss;
    logic [15:0] m_fc;
    logic [31:0] m_win;
    bit          exp_rdy;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: the stream is a repeating period of FB payload
    // bits followed by SW sync bits once locked; position alone decides roles.
    always @(posedge clk) begin
        if (rst) begin
            m_locked = 0; m_occ = 0; m_od = 0; m_oa = 0; m_lost = 0;
            m_fill = 0; m_pos = 0; m_miss = 0; m_fc = '0; m_win = '0;
        end else begin
            m_lost = 0;
            m_rdy = !(m_locked && m_pos < FB) || !m_occ || out_ready;
            if (m_occ && out_ready) m_occ = 0;
            if (in_valid && m_rdy) begin
                m_win = {m_win[30:0], in_data};
                m_hit = ($countones(m_win ^ SYNC) == 0);
                if (!m_locked) begin
                    m_fill++;
                    if (m_fill >= SW && m_hit) begin
                        m_locked = 1; m_fc = m_fc + 16'd1; m_pos = 0;
                    end
                end else if (m_pos < FB) begin
                    m_occ = 1; m_od = in_data; m_oa = (m_pos == 0); m_pos++;
                end else begin
                    m_pos++;
                    if (m_pos == FB + SW) begin
                        m_pos = 0;
                        if (m_hit) begin
                            m_miss = 0; m_fc = m_fc + 16'd1;
                        end else begin
                            m_miss++;
                            if (m_miss == ML) begin
                                m_locked = 0; m_lost = 1; m_miss = 0; m_fill = 0;
                            end
                        end
                    end
                end
            end
        end
    end

    // Every-cycle comparison of the main DUT against the model, plus output capture.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_rdy = !rst && (!(m_locked && m_pos < FB) || !m_occ || out_ready);
            checkOutput("in_ready", 64'(in_ready), 64'(exp_rdy));
            checkOutput("out_valid", 64'(out_valid), 64'(m_occ));
            checkOutput("locked", 64'(locked), 64'(m_locked));
            checkOutput("sync_lost", 64'(sync_lost), 64'(m_lost));
            checkOutput("frame_count", 64'(frame_count), 64'(m_fc));
            if (m_occ) begin
                checkOutput("out_data", 64'(out_data), 64'(m_od));
                checkOutput("out_align", 64'(out_align), 64'(m_oa));
            end
            if (sync_lost === 1'b1) lost_pulses++;
            if (!rst && out_valid === 1'b1 && out_ready) got_q.push_back({out_data, out_align});
        end
    end

    // Downstream ready: steady high, or 1-on/3-off while backpressure is enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                out_ready = (bp_cnt % 4 == 0);
                bp_cnt++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic send_bit(input logic b);
        bit ok;
        if ($urandom_range(0, 4) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        ok = 0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = (in_ready === 1'b1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got no accept expected accept within 50 cycles");
        end
    endtask

    task automatic applyStimulus(input logic [63:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_random(input int n);
        for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_payload(input string name, input logic [63:0] p, input int s);
        logic [63:0] d, a;
        d = '0;
        a = '0;
        if (got_q.size() < s + 64) begin
            checkOutput({name, "_count"}, 64'(got_q.size()), 64'(s + 64));
        end else begin
            for (int i = 0; i < 64; i++) begin
                d[63-i] = got_q[s+i][1];
                a[63-i] = got_q[s+i][0];
            end
            checkOutput({name, "_data"}, d, p);
            checkOutput({name, "_align"}, a, 64'h8000_0000_0000_0000);
        end
    endtask

    logic [63:0] pay;
    int          lost_before;

    initial begin
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        checkOutput("reset_locked", 64'(locked), 64'd0);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_frame_count", 64'(frame_count), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_reset_in_ready", 64'(in_ready), 64'd1);

        $display("[TB] acquisition");
        got_q.delete();
        send_random(40);
        applyStimulus(64'(SYNC), 32);
        checkOutput("acq_locked", 64'(locked), 64'd1);
        applyStimulus(64'hA5A5A5A5_CCCCCCCC, 64);
        applyStimulus(64'(SYNC), 32);
        drain();
        checkOutput("acq_count", 64'(got_q.size()), 64'd64);
        if (got_q.size() > 0) checkOutput("acq_first", 64'(got_q[0]), 64'd3);
        check_payload("acq", 64'hA5A5A5A5_CCCCCCCC, 0);
        checkOutput("acq_frame_count", 64'(frame_count), 64'd2);

        $display("[TB] flywheel");
        got_q.delete();
        pay = {$urandom, $urandom};
        applyStimulus(pay, 64);
        applyStimulus(64'(SYNC ^ 32'h0000_0020), 32);
        checkOutput("fly_locked", 64'(locked), 64'd1);
        checkOutput("fly_frame_count", 64'(frame_count), 64'd2);
        applyStimulus(64'hF0F0_1234_5678_0F0F, 64);
        applyStimulus(64'(SYNC), 32);
        drain();
        check_payload("fly_p1", pay, 0);
        check_payload("fly_p2", 64'hF0F0_1234_5678_0F0F, 64);
        checkOutput("fly_recover_count", 64'(frame_count), 64'd3);

        $display("[TB] loss");
        lost_before = lost_pulses;
        send_random(64);
        applyStimulus(64'(~SYNC), 32);
        send_random(64);
        applyStimulus(64'(SYNC ^ 32'h0001_0000), 32);
        checkOutput("loss_pulse", 64'(sync_lost), 64'd1);
        checkOutput("loss_locked", 64'(locked), 64'd0);
        drain();
        checkOutput("loss_pulse_count", 64'(lost_pulses - lost_before), 64'd1);
        got_q.delete();
        send_random(80);
        drain();
        checkOutput("loss_no_output", 64'(got_q.size()), 64'd0);

        $display("[TB] backpressure");
        do_reset();
        got_q.delete();
        send_random(10);
        applyStimulus(64'(SYNC), 32);
        pay = {$urandom, $urandom};
        bp_mode = 1'b1;
        applyStimulus(pay, 64);
        drain();
        bp_mode = 1'b0;
        applyStimulus(64'(SYNC), 32);
        drain();
        checkOutput("bp_count", 64'(got_q.size()), 64'd64);
        check_payload("bp", pay, 0);

        $display("[TB] tolerance and fill");
        do_reset();
        applyStimulus(64'(SYNC[30:0]), 31);
        checkOutput("fill_no_lock", 64'(locked), 64'd0);
        checkOutput("fill_no_lock_tol", 64'(t_locked), 64'd0);
        send_random(8);
        applyStimulus(64'(SYNC ^ 32'h0000_0080), 32);
        checkOutput("tol_lock", 64'(t_locked), 64'd1);
        checkOutput("tol_strict_no_lock", 64'(locked), 64'd0);

        $display("[TB] reset mid-frame");
        do_reset();
        applyStimulus(64'(SYNC), 32);
        send_random(20);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_locked", 64'(locked), 64'd0);
        checkOutput("rst_frame_count", 64'(frame_count), 64'd0);
        got_q.delete();
        send_random(12);
        applyStimulus(64'(SYNC), 32);
        pay = {$urandom, $urandom};
        applyStimulus(pay, 64);
        applyStimulus(64'(SYNC), 32);
        drain();
        check_payload("rst_reacq", pay, 0);
        checkOutput("rst_reacq_count", 64'(frame_count), 64'd2);

        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
